// File: rtl/irq_arbiter_if.sv
// Register-bus and interrupt signals of irq_arbiter. The slave modport is the arbiter side
// and the master modport is the bus and source side.
interface irq_arbiter_if #(
  parameter int unsigned NUM_SRC = 8
);
  logic [NUM_SRC-1:0] irq_src_i;
  logic               reg_we_i;
  logic               reg_re_i;
  logic [7:0]         reg_addr_i;
  logic [31:0]        reg_wdata_i;
  logic [31:0]        reg_rdata_o;
  logic               irq_o;
  logic [7:0]         irq_id_o;

  modport slave (
    input  irq_src_i, reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
    output reg_rdata_o, irq_o, irq_id_o
  );

  modport master (
    output irq_src_i, reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
    input  reg_rdata_o, irq_o, irq_id_o
  );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter with edge-triggered gateways, priority/threshold arbitration and a
// claim/complete handshake over a simple register bus.
module irq_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input logic          clk,
  input logic          rst_n,
  irq_arbiter_if.slave bus
);
  localparam logic [7:0] AddrPending   = 8'h00;
  localparam logic [7:0] AddrEnable    = 8'h04;
  localparam logic [7:0] AddrThreshold = 8'h08;
  localparam logic [7:0] AddrClaim     = 8'h0C;

  function automatic logic [7:0] prio_addr(int unsigned idx);
    return 8'(32'h20 + 4 * idx);
  endfunction

  logic [NUM_SRC-1:0] r_sync1, r_sync2, r_prev;
  logic [NUM_SRC-1:0] r_pending, r_in_service, r_enable;
  logic [PRIO_W-1:0]  r_threshold;
  logic [PRIO_W-1:0]  r_prio [NUM_SRC];
  logic [31:0]        r_rdata;
  logic               r_irq;
  logic [7:0]         r_irq_id;

  logic [NUM_SRC-1:0] w_set, w_claim_mask, w_complete_mask;
  logic               w_claim, w_complete;
  logic               w_found;
  logic [PRIO_W-1:0]  w_best_prio;
  logic [7:0]         w_best_id;
  logic [31:0]        w_rdata;
  logic               w_unused_wdata;

  assign w_unused_wdata = ^bus.reg_wdata_i;

  assign w_claim    = bus.reg_re_i && (bus.reg_addr_i == AddrClaim) && (r_irq_id != 8'd0);
  assign w_complete = bus.reg_we_i && (bus.reg_addr_i == AddrClaim);

  // An edge is dropped while its source is pending or in service; this also covers an edge
  // coinciding with a claim or a complete of the same source.
  always_comb begin
    w_set           = '0;
    w_claim_mask    = '0;
    w_complete_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_set[i]           = r_sync2[i] && !r_prev[i] && !r_pending[i] && !r_in_service[i];
      w_claim_mask[i]    = w_claim && (r_irq_id == 8'(i + 1));
      w_complete_mask[i] = w_complete && (bus.reg_wdata_i[7:0] == 8'(i + 1));
    end
  end

  // Strict '>' on the running best keeps the lowest ID on ties.
  always_comb begin
    w_found     = 1'b0;
    w_best_prio = '0;
    w_best_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_pending[i] && r_enable[i] && (r_prio[i] > r_threshold) &&
          (!w_found || (r_prio[i] > w_best_prio))) begin
        w_found     = 1'b1;
        w_best_prio = r_prio[i];
        w_best_id   = 8'(i + 1);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.reg_addr_i == AddrPending) begin
      w_rdata[NUM_SRC-1:0] = r_pending;
    end else if (bus.reg_addr_i == AddrEnable) begin
      w_rdata[NUM_SRC-1:0] = r_enable;
    end else if (bus.reg_addr_i == AddrThreshold) begin
      w_rdata[PRIO_W-1:0] = r_threshold;
    end else if (bus.reg_addr_i == AddrClaim) begin
      w_rdata[7:0] = r_irq_id;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.reg_addr_i == prio_addr(i)) w_rdata[PRIO_W-1:0] = r_prio[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_prev       <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_enable     <= '0;
      r_threshold  <= '0;
      r_rdata      <= '0;
      r_irq        <= 1'b0;
      r_irq_id     <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
    end else begin
      r_sync1      <= bus.irq_src_i;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_pending    <= (r_pending | w_set) & ~w_claim_mask;
      r_in_service <= (r_in_service | w_claim_mask) & ~w_complete_mask;
      r_irq        <= w_found;
      r_irq_id     <= w_best_id;
      if (bus.reg_re_i) r_rdata <= w_rdata;
      if (bus.reg_we_i) begin
        if (bus.reg_addr_i == AddrEnable) r_enable <= bus.reg_wdata_i[NUM_SRC-1:0];
        if (bus.reg_addr_i == AddrThreshold) r_threshold <= bus.reg_wdata_i[PRIO_W-1:0];
        for (int i = 0; i < NUM_SRC; i++) begin
          if (bus.reg_addr_i == prio_addr(i)) r_prio[i] <= bus.reg_wdata_i[PRIO_W-1:0];
        end
      end
    end
  end

  assign bus.reg_rdata_o = r_rdata;
  assign bus.irq_o       = r_irq;
  assign bus.irq_id_o    = r_irq_id;

endmodule
